adder_share_ctrl: RTL and testbench

Two-requester scheduler that time-shares the single 32-bit ripple-carry adder (33-bit result: carry-out in bit 32, plus signed-overflow flag) in the processor datapath. The block arbitrates round-robin between requester 0 and requester 1 and registers the granted operands to drive the external adder. It captures the adder result into a response register and returns it, tagged with the requester ID, over a valid/ready channel. It owns no arithmetic; the adder instance sits outside and connects through the `add_*` ports.

---
 rtl/adder_share_ctrl.sv | 162 ++++++++++++++++
 tb/tb_adder_share_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// Round-robin scheduler sharing one external 32-bit adder between two requesters.
// Registers granted operands toward the adder and returns the tagged result over valid/ready.
module adder_share_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  output logic             req0_ready,

  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             req1_ready,

  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [32:0]      add_r,
  input  logic             add_ovf,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_sum,
  output logic             rsp_carry,
  output logic             rsp_ovf,

  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q, state_d;

  // Requester that wins when both are valid; flips to the loser on every grant.
  logic rr_prio_q, rr_prio_d;

  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        op_id_q, op_id_d;

  logic [31:0] rsp_sum_q, rsp_sum_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_id_q, rsp_id_d;

  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic can_accept;
  logic rsp_take;
  logic grant;
  logic grant_id;

  // Arbitration
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = rr_prio_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign rsp_take   = (state_q == StResp) && rsp_ready;
  assign can_accept = (state_q == StIdle) || rsp_take;
  assign grant      = can_accept && (req0_valid || req1_valid);

  assign req0_ready = grant && !grant_id;
  assign req1_ready = grant && grant_id;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant) state_d = StExec;
      end
      StExec: begin
        state_d = StResp;
      end
      StResp: begin
        if (rsp_take) state_d = grant ? StExec : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rr_prio_d = rr_prio_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_id_d   = op_id_q;
    if (grant) begin
      rr_prio_d = !grant_id;
      op_id_d   = grant_id;
      op_a_d    = grant_id ? req1_a : req0_a;
      op_b_d    = grant_id ? req1_b : req0_b;
    end
  end

  // Response capture happens only in EXEC, so fields hold through backpressure.
  always_comb begin
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_id_d    = rsp_id_q;
    if (state_q == StExec) begin
      rsp_sum_d   = add_r[31:0];
      rsp_carry_d = add_r[32];
      rsp_ovf_d   = add_ovf;
      rsp_id_d    = op_id_q;
    end
  end

  always_comb begin
    ops_done_d = ops_done_q;
    if (rsp_take) ops_done_d = ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_prio_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_prio_q   <= rr_prio_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_id_q    <= rsp_id_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign add_a     = op_a_q;
  assign add_b     = op_b_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = (state_q == StExec) || (state_q == StResp);
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with a behavioural model of the external adder.
module tb_adder_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic [31:0] add_a, add_b;
  logic [32:0] add_r;
  logic        add_ovf;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_ovf;
  logic [31:0] rsp_sum;
  logic        busy;
  logic [3:0]  ops_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_cnt;

  always #5 clk = ~clk;

  // External ripple-carry adder stand-in
  always_comb begin
    add_r   = {1'b0, add_a} + {1'b0, add_b};
    add_ovf = (add_a[31] == add_b[31]) && (add_r[31] != add_a[31]);
  end

  adder_share_ctrl #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_r      (add_r),
    .add_ovf    (add_ovf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_carry  (rsp_carry),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation from IDLE with rsp_ready held high; ends 1ns after a rising edge.
  task automatic run_single(input logic id, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] es, input logic ec, input logic ev);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    @(negedge clk);
    check_eq("single_ready0", 64'(req0_ready), 64'(!id));
    check_eq("single_ready1", 64'(req1_ready), 64'(id));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("exec_busy", 64'(busy), 64'd1);
    check_eq("exec_add_a", 64'(add_a), 64'(a));
    check_eq("exec_add_b", 64'(add_b), 64'(b));
    check_eq("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    check_eq("resp_valid", 64'(rsp_valid), 64'd1);
    check_eq("resp_id", 64'(rsp_id), 64'(id));
    check_eq("resp_sum", 64'(rsp_sum), 64'(es));
    check_eq("resp_carry", 64'(rsp_carry), 64'(ec));
    check_eq("resp_ovf", 64'(rsp_ovf), 64'(ev));
    tick();
    exp_cnt = exp_cnt + 4'd1;
    @(negedge clk);
    check_eq("ops_done", 64'(ops_done), 64'(exp_cnt));
    check_eq("idle_busy", 64'(busy), 64'd0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    exp_cnt = 4'd0;

    // Reset values
    @(negedge clk);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ops_done", 64'(ops_done), 64'd0);
    check_eq("rst_add_a", 64'(add_a), 64'd0);
    check_eq("rst_add_b", 64'(add_b), 64'd0);
    check_eq("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
    check_eq("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single add, then carry-out and signed overflow from requester 1
    run_single(1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    run_single(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    run_single(1'b1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);

    // Contention: last grant went to 1, so requester 0 is favoured first
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("cont_ready0", 64'(req0_ready), 64'(k % 2 == 0));
      check_eq("cont_ready1", 64'(req1_ready), 64'(k % 2 == 1));
      if (k > 0) begin
        check_eq("cont_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("cont_rsp_id", 64'(rsp_id), 64'((k - 1) % 2));
        check_eq("cont_rsp_sum", 64'(rsp_sum), ((k - 1) % 2 == 1) ? 64'd7 : 64'd3);
        exp_cnt = exp_cnt + 4'd1;
      end
      tick();
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      check_eq("cont_exec_ready", 64'({req0_ready, req1_ready}), 64'd0);
      tick();
    end
    @(negedge clk);
    check_eq("cont_last_id", 64'(rsp_id), 64'd1);
    check_eq("cont_last_sum", 64'(rsp_sum), 64'd7);
    tick();
    exp_cnt = exp_cnt + 4'd1;
    @(negedge clk);
    check_eq("cont_ops_done", 64'(ops_done), 64'(exp_cnt));
    tick();

    // Backpressure with req1 pending
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20;
    @(negedge clk);
    check_eq("bp_ready0", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h11; req1_b = 32'h22;
    @(negedge clk);
    check_eq("bp_exec_ready1", 64'(req1_ready), 64'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("bp_hold_sum", 64'(rsp_sum), 64'd30);
      check_eq("bp_hold_id", 64'(rsp_id), 64'd0);
      check_eq("bp_hold_ready1", 64'(req1_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready1", 64'(req1_ready), 64'd1);
    check_eq("bp_release_sum", 64'(rsp_sum), 64'd30);
    tick();
    req1_valid = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    @(negedge clk);
    check_eq("bp_ops_done", 64'(ops_done), 64'(exp_cnt));
    tick();
    @(negedge clk);
    check_eq("bp_rsp_id", 64'(rsp_id), 64'd1);
    check_eq("bp_rsp_sum", 64'(rsp_sum), 64'h33);
    tick();
    tick();

    // Asynchronous reset while in EXEC
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
    tick();
    req0_valid = 1'b0;
    #2;
    check_eq("arst_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_add_a", 64'(add_a), 64'd0);
    check_eq("arst_ops_done", 64'(ops_done), 64'd0);
    check_eq("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt = 4'd0;
    tick();
    run_single(1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);

    // Counter wrap at CNT_W=4: 17 operations from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 4'd0;
    tick();
    for (int i = 0; i < 17; i++) begin
      run_single(1'(i % 2), 32'(i), 32'd100, 32'(i + 100), 1'b0, 1'b0);
      if (i == 15) check_eq("wrap_zero", 64'(ops_done), 64'd0);
    end
    check_eq("wrap_one", 64'(ops_done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Exclusivity and valid-gating of grants on every cycle
  always @(negedge clk) begin
    if (rst_n && (req0_ready || req1_ready)) begin
      check_eq("ready_onehot", 64'(req0_ready && req1_ready), 64'd0);
      check_eq("ready_gated", 64'((req0_ready && !req0_valid) || (req1_ready && !req1_valid)),
               64'd0);
    end
  end

endmodule
